// File: rtl/idct_transpose4_if.sv
// Row-in / column-out handshake bundle for the 4x4 IDCT transpose buffer.
// The master is the row producer and column consumer; the slave is the buffer.
interface idct_transpose4_if #(
  parameter int DW = 25
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_d0;
  logic signed [DW-1:0] in_d1;
  logic signed [DW-1:0] in_d2;
  logic signed [DW-1:0] in_d3;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_d0;
  logic signed [DW-1:0] out_d1;
  logic signed [DW-1:0] out_d2;
  logic signed [DW-1:0] out_d3;
  logic [1:0]           out_col;
  logic                 out_last;

  modport master (
    output in_valid, in_d0, in_d1, in_d2, in_d3, out_ready,
    input  in_ready, out_valid, out_d0, out_d1, out_d2, out_d3, out_col, out_last
  );

  modport slave (
    input  in_valid, in_d0, in_d1, in_d2, in_d3, out_ready,
    output in_ready, out_valid, out_d0, out_d1, out_d2, out_d3, out_col, out_last
  );
endinterface

// File: rtl/idct_transpose4.sv
// Ping-pong 4x4 transpose buffer between the row and column IDCT passes.
// Rows are saturated to SW bits on entry and read back out column by column.
module idct_transpose4 #(
  parameter int DW = 25,
  parameter int SW = 16
) (
  input logic             clk,
  input logic             reset,
  idct_transpose4_if.slave bus
);

  typedef logic signed [SW-1:0] samp_t;

  localparam logic signed [DW-1:0] SAT_HI = {{(DW-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_LO = {{(DW-SW+1){1'b1}}, {(SW-1){1'b0}}};

  samp_t      mem [2][4][4];
  logic [1:0] full;
  logic       wb;
  logic       rb;
  logic [1:0] wptr;
  logic [1:0] rptr;

  logic signed [DW-1:0] in_row [4];
  logic                 accept;
  logic                 consume;

  assign in_row[0] = bus.in_d0;
  assign in_row[1] = bus.in_d1;
  assign in_row[2] = bus.in_d2;
  assign in_row[3] = bus.in_d3;

  function automatic samp_t saturate(input logic signed [DW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[SW-1:0];
    else if (v < SAT_LO) return SAT_LO[SW-1:0];
    else                 return v[SW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] sext(input samp_t s);
    return {{(DW-SW){s[SW-1]}}, s};
  endfunction

  // Accept and consume never touch the same bank: accept needs full[wb]==0,
  // consume needs full[rb]==1, so both can update state in one cycle.
  assign accept  = bus.in_valid && !full[wb];
  assign consume = full[rb] && bus.out_ready;

  // NOTE: the storage array is reset too, so out_d* reads as zero after reset
  // rather than exposing stale samples from an abandoned block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= '0;
      wb   <= 1'b0;
      rb   <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            mem[b][r][c] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every read in this block on the
      // pre-edge values of wb/rb/wptr/rptr, independent of statement order.
      if (accept) begin
        for (int j = 0; j < 4; j++)
          mem[wb][wptr][j] <= saturate(in_row[j]);
        wptr <= wptr + 2'd1;
        if (wptr == 2'd3) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
        end
      end
      if (consume) begin
        rptr <= rptr + 2'd1;
        if (rptr == 2'd3) begin
          full[rb] <= 1'b0;
          rb       <= ~rb;
        end
      end
    end
  end

  // A bank released this cycle only shows as ready once full[] has updated.
  assign bus.in_ready  = !full[wb];
  assign bus.out_valid = full[rb];
  assign bus.out_col   = rptr;
  assign bus.out_last  = full[rb] && (rptr == 2'd3);
  assign bus.out_d0    = sext(mem[rb][0][rptr]);
  assign bus.out_d1    = sext(mem[rb][1][rptr]);
  assign bus.out_d2    = sext(mem[rb][2][rptr]);
  assign bus.out_d3    = sext(mem[rb][3][rptr]);

endmodule

// File: tb/tb_idct_transpose4.sv
// Self-checking bench for idct_transpose4: a row/column queue model checked every
// cycle, plus directed literal checks for transpose, saturation and backpressure.
module tb_idct_transpose4;

  localparam int DW = 25;
  localparam int SW = 16;

  typedef logic [3:0][DW-1:0] row_t;
  typedef struct packed {
    logic [3:0][DW-1:0] d;
    logic [1:0]         col;
  } col_t;

  logic clk;
  logic reset;
  logic rand_ready;
  int   checks;
  int   failures;
  int   cols_out;

  row_t part[$];
  col_t expq[$];

  idct_transpose4_if #(.DW(DW)) ifc ();

  idct_transpose4 #(.DW(DW), .SW(SW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference saturation done in plain integer arithmetic.
  function automatic logic [DW-1:0] model_sat(input logic signed [DW-1:0] v);
    int x;
    x = int'(v);
    if (x > (1 << (SW-1)) - 1) x = (1 << (SW-1)) - 1;
    if (x < -(1 << (SW-1)))    x = -(1 << (SW-1));
    return DW'(x);
  endfunction

  function automatic int rnd_sample();
    logic signed [DW-1:0] t;
    case ($urandom_range(2))
      0:       return int'($urandom_range(0, 80000)) - 40000;
      1: begin
        t = DW'($urandom);
        return int'(t);
      end
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  // Model: rows accumulate until a block is complete, then its four columns queue
  // up in order. A block occupies a bank until its last column leaves.
  always @(negedge clk) begin
    int   held;
    col_t e;
    col_t c;
    row_t r;
    if (reset) begin
      part.delete();
      expq.delete();
      check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
      check("rst_out_last", 32'(ifc.out_last), 32'd0);
      check("rst_out_col", 32'(ifc.out_col), 32'd0);
      check_d("rst_out_d0", ifc.out_d0, '0);
      check_d("rst_out_d3", ifc.out_d3, '0);
    end else begin
      held = (expq.size() + 3) / 4;
      check("in_ready", 32'(ifc.in_ready), 32'(held < 2));
      check("out_valid", 32'(ifc.out_valid), 32'(expq.size() != 0));
      if (ifc.out_valid && expq.size() != 0) begin
        e = expq[0];
        check_d("out_d0", ifc.out_d0, e.d[0]);
        check_d("out_d1", ifc.out_d1, e.d[1]);
        check_d("out_d2", ifc.out_d2, e.d[2]);
        check_d("out_d3", ifc.out_d3, e.d[3]);
        check("out_col", 32'(ifc.out_col), 32'(e.col));
        check("out_last", 32'(ifc.out_last), 32'(e.col == 2'd3));
      end else begin
        check("out_last_idle", 32'(ifc.out_last), 32'd0);
      end
      if (ifc.out_valid && ifc.out_ready && expq.size() != 0) begin
        void'(expq.pop_front());
        cols_out++;
      end
      if (ifc.in_valid && ifc.in_ready) begin
        r[0] = model_sat(ifc.in_d0);
        r[1] = model_sat(ifc.in_d1);
        r[2] = model_sat(ifc.in_d2);
        r[3] = model_sat(ifc.in_d3);
        part.push_back(r);
        if (part.size() == 4) begin
          for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) c.d[j] = part[j][k];
            c.col = 2'(k);
            expq.push_back(c);
          end
          part.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      ifc.out_ready = 1'($urandom_range(1));
    end
  end

  // Called 1 time unit after a rising edge; returns 1 time unit after the
  // rising edge that accepted the row, with in_valid still high.
  task automatic send_row(input int a, input int b, input int c, input int d, output int stalls);
    int n;
    n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_d0 = DW'(a);
    ifc.in_d1 = DW'(b);
    ifc.in_d2 = DW'(c);
    ifc.in_d3 = DW'(d);
    @(negedge clk);
    while (!ifc.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("row_accept_bound", 32'(n), 32'd0);
    stalls = n;
    @(posedge clk);
    #1;
  endtask

  task automatic send_rnd(output int stalls);
    send_row(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), stalls);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || ifc.out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_bound", 32'(n < 2000), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int tot;
    int c0;
    logic [DW-1:0] sat_exp [4];

    checks = 0; failures = 0; cols_out = 0;
    rand_ready = 1'b0;
    reset = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_d0 = '0; ifc.in_d1 = '0; ifc.in_d2 = '0; ifc.in_d3 = '0;
    ifc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Basic transpose with literal expectations.
    ifc.out_ready = 1'b1;
    send_row(1, 2, 3, 4, st);
    send_row(5, 6, 7, 8, st);
    send_row(9, 10, 11, 12, st);
    send_row(13, 14, 15, 16, st);
    ifc.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("basic_valid", 32'(ifc.out_valid), 32'd1);
      check_d("basic_d0", ifc.out_d0, DW'(c + 1));
      check_d("basic_d1", ifc.out_d1, DW'(c + 5));
      check_d("basic_d2", ifc.out_d2, DW'(c + 9));
      check_d("basic_d3", ifc.out_d3, DW'(c + 13));
      check("basic_col", 32'(ifc.out_col), 32'(c));
      check("basic_last", 32'(ifc.out_last), 32'(c == 3));
    end
    @(negedge clk);
    check("basic_drained", 32'(ifc.out_valid), 32'd0);
    @(posedge clk); #1;

    // Saturation.
    sat_exp[0] = 25'd32767;
    sat_exp[1] = 25'h1FF8000;
    sat_exp[2] = 25'd32767;
    sat_exp[3] = 25'h1FFFFFF;
    repeat (4) send_row(40000, -40000, 32767, -1, st);
    ifc.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_d("sat_d0", ifc.out_d0, sat_exp[c]);
      check_d("sat_d1", ifc.out_d1, sat_exp[c]);
      check_d("sat_d2", ifc.out_d2, sat_exp[c]);
      check_d("sat_d3", ifc.out_d3, sat_exp[c]);
    end
    @(posedge clk); #1;

    // Backpressure: two banks fill, the 9th row waits for bank 0 to drain.
    ifc.out_ready = 1'b0;
    repeat (8) send_rnd(st);
    ifc.in_d0 = DW'(rnd_sample());
    ifc.in_d1 = DW'(rnd_sample());
    repeat (4) begin
      @(negedge clk);
      check("bp_full", 32'(ifc.in_ready), 32'd0);
      check("bp_pending", 32'(ifc.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    ifc.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_hold", 32'(ifc.in_ready), 32'd0);
      check("bp_col", 32'(ifc.out_col), 32'(c));
    end
    @(negedge clk);
    check("bp_release", 32'(ifc.in_ready), 32'd1);
    check("bp_bank1_col", 32'(ifc.out_col), 32'd0);
    @(posedge clk); #1;
    repeat (3) send_rnd(st);
    ifc.in_valid = 1'b0;
    wait_drain();

    // Reset mid-block discards the partial block.
    send_rnd(st);
    send_rnd(st);
    ifc.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(ifc.out_valid), 32'd0);
    check("midrst_ready", 32'(ifc.in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    send_row(101, 102, 103, 104, st);
    send_row(105, 106, 107, 108, st);
    send_row(109, 110, 111, 112, st);
    send_row(113, 114, 115, 116, st);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check_d("midrst_d0", ifc.out_d0, DW'(101));
    check_d("midrst_d1", ifc.out_d1, DW'(105));
    check("midrst_col", 32'(ifc.out_col), 32'd0);
    @(posedge clk); #1;
    wait_drain();

    // Streaming: 64 back-to-back rows with no stalls.
    tot = 0;
    c0 = cols_out;
    for (int i = 0; i < 64; i++) begin
      send_rnd(st);
      tot += st;
    end
    ifc.in_valid = 1'b0;
    wait_drain();
    check("stream_stalls", 32'(tot), 32'd0);
    check("stream_cols", 32'(cols_out - c0), 32'd64);

    // Random handshake over 1000 blocks.
    c0 = cols_out;
    rand_ready = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      while ($urandom_range(3) == 0) begin
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      send_rnd(st);
    end
    ifc.in_valid = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk); #2;
    ifc.out_ready = 1'b1;
    wait_drain();
    check("rand_cols", 32'(cols_out - c0), 32'd4000);
    check("rand_partial", 32'(part.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idct_transpose4.md
IDCT_TRANSPOSE4 -- requirements
Module: idct_transpose4

Block: 4x4 transpose buffer between the first (row) IDCT pass and the second (column) IDCT pass. It accepts one 4-sample row per handshake, saturates each sample, and emits the 4x4 block column by column. Two banks (ping-pong) allow continuous streaming.

Interface
REQ-001 Parameter DW, default 25: width of the input and output sample ports.
REQ-002 Parameter SW, default 16: width of the saturated stored sample.
REQ-003 The block SHALL provide these ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: row present on in_d0..in_d3.
- in_ready, output, 1: block can accept a row.
- in_d0..in_d3, input, DW signed: row samples for columns 0..3.
- out_valid, output, 1: column present on out_d0..out_d3.
- out_ready, input, 1: downstream accepts the column.
- out_d0..out_d3, output, DW signed: column samples for rows 0..3, sign-extended from SW.
- out_col, output, 2: index of the column currently presented.
- out_last, output, 1: high when out_col==3 and out_valid==1.

Function
REQ-004 A row SHALL be accepted on a rising edge where in_valid && in_ready; a column SHALL be consumed on a rising edge where out_valid && out_ready.
REQ-005 Each accepted sample SHALL be saturated to SW-bit signed before storage: values >32767 store as 32767, values <-32768 store as -32768, all other values store unchanged.
REQ-006 Storage SHALL be two banks of 4x4 SW-bit registers, each with a full flag; control SHALL use a write-bank bit wb, a read-bank bit rb, a 2-bit row pointer wptr and a 2-bit column pointer rptr.
REQ-007 in_ready SHALL equal !full[wb].
REQ-008 On accept, sample in_dJ SHALL be written to bank[wb][wptr][J] and wptr SHALL increment.
REQ-009 On accept with wptr==3:
- full[wb] SHALL set;
- wb SHALL toggle;
- wptr SHALL wrap to 0.
REQ-010 out_valid SHALL equal full[rb].
REQ-011 out_dK SHALL equal bank[rb][K][rptr], sign-extended to DW; out_col SHALL equal rptr.
REQ-012 On consume, rptr SHALL increment.
REQ-013 On consume with rptr==3:
- full[rb] SHALL clear;
- rb SHALL toggle;
- rptr SHALL wrap to 0.
REQ-014 Latency: column 0 of a block SHALL be valid in the cycle immediately after that block's 4th row is accepted.
REQ-015 Throughput: with out_ready held high, the block SHALL sustain 1 row in and 1 column out per cycle with in_ready never deasserting.
REQ-016 While out_valid && !out_ready, out_d*, out_col and out_last SHALL hold stable.
REQ-017 A simultaneous accept and consume in the same cycle SHALL be handled independently, because they always target different banks.
REQ-018 A bank freed by a consume in cycle N SHALL be writable in cycle N+1, not in cycle N.
REQ-019 Blocks SHALL be emitted in exactly the order they were received; no block SHALL be overwritten or dropped.

Reset
REQ-020 While reset is high, the block SHALL force:
- full[0]=full[1]=0, wb=rb=0, wptr=rptr=0, all storage to 0;
- out_valid=0, out_last=0, out_col=0, out_d*=0;
- in_ready=1.
REQ-021 Reset asserted mid-block SHALL discard all partially written and pending blocks; the first row accepted after reset deasserts SHALL be row 0 of bank 0.

Verification
REQ-022 Basic transpose, out_ready=1: push rows [1,2,3,4], [5,6,7,8], [9,10,11,12], [13,14,15,16] -> out_valid rises the next cycle; columns emerge in order [1,5,9,13], [2,6,10,14], [3,7,11,15], [4,8,12,16] with out_col 0..3; out_last=1 only on the 4th column.
REQ-023 Saturation: row [40000, -40000, 32767, -1] repeated 4 times -> every column is [32767x4], [-32768x4], [32767x4], [-1x4]; -1 appears as 25'h1FFFFFF.
REQ-024 Backpressure: out_ready=0, push 8 rows -> in_ready=0 after the 8th accept and a 9th row is held unaccepted; raise out_ready -> bank 0 columns emerge, then bank 1 columns, and the 9th row is accepted the cycle after bank 0's last column is consumed.
REQ-025 Streaming: out_ready=1, 64 consecutive rows with in_valid=1 -> in_ready stays 1 throughout; 16 blocks (64 columns) emerge back-to-back, each matching the transpose of its input block.
REQ-026 Reset mid-operation: accept 2 rows, pulse reset -> out_valid=0 and in_ready=1 immediately; then 4 new rows -> only the new block is output.
REQ-027 Random handshake: random in_valid/out_ready over 1000 blocks -> output matches the transposed, saturated scoreboard exactly, and outputs stay stable during every stall.
